// File: rtl/genesis_pad_reader_if.sv
// rtl/genesis_pad_reader_if.sv - pad pins and de-multiplexed button outputs of one joypad port
interface genesis_pad_reader_if;
  logic       pad_up;
  logic       pad_down;
  logic       pad_left;
  logic       pad_right;
  logic       pad_a_b;
  logic       pad_c_s;
  logic       pad_sel;
  logic [7:0] buttons;
  logic       present;
  logic       update;

  modport master (
    input  pad_up, pad_down, pad_left, pad_right, pad_a_b, pad_c_s,
    output pad_sel, buttons, present, update
  );

  modport slave (
    output pad_up, pad_down, pad_left, pad_right, pad_a_b, pad_c_s,
    input  pad_sel, buttons, present, update
  );
endinterface

// File: rtl/genesis_pad_reader.sv
// rtl/genesis_pad_reader.sv - 3-button Genesis joypad scanner with select toggling and demux
module genesis_pad_reader #(
  parameter int SEL_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 40
) (
  input  logic                  clock,
  input  logic                  reset,
  genesis_pad_reader_if.master  bus
);
  localparam int CW = $clog2(SEL_CYCLES);
  localparam logic [CW-1:0] LAST_CNT   = CW'(SEL_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SETTLE_CYCLES - 1);

  typedef enum logic {PH_HIGH, PH_LOW} phase_t;

  // Pin vectors are ordered {up, down, left, right, a_b, c_s}.
  logic [5:0]    pins;
  logic [5:0]    sync1;
  logic [5:0]    sync2;
  logic [5:0]    hi_sample;
  logic [CW-1:0] cnt;
  phase_t        phase;
  logic          pad_sel_q;
  logic [7:0]    buttons_q;
  logic          present_q;
  logic          update_q;

  assign pins = {bus.pad_up, bus.pad_down, bus.pad_left, bus.pad_right, bus.pad_a_b, bus.pad_c_s};

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1     <= 6'h3f;
      sync2     <= 6'h3f;
      hi_sample <= 6'h3f;
      cnt       <= '0;
      phase     <= PH_HIGH;
      pad_sel_q <= 1'b1;
      buttons_q <= 8'h00;
      present_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      sync1    <= pins;
      sync2    <= sync1;
      update_q <= 1'b0;

      if (cnt == LAST_CNT) begin
        cnt <= '0;
        if (phase == PH_HIGH) begin
          phase     <= PH_LOW;
          pad_sel_q <= 1'b0;
        end else begin
          phase     <= PH_HIGH;
          pad_sel_q <= 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (cnt == SAMPLE_CNT) begin
        if (phase == PH_HIGH) begin
          hi_sample <= sync2;
        end else begin
          // A 3-button pad pulls left and right low while select is low.
          present_q <= !sync2[3] && !sync2[2];
          if (!sync2[3] && !sync2[2]) begin
            buttons_q <= {~sync2[0], ~hi_sample[0], ~hi_sample[1], ~sync2[1],
                          ~hi_sample[2], ~hi_sample[3], ~hi_sample[4], ~hi_sample[5]};
          end else begin
            buttons_q <= 8'h00;
          end
          update_q <= 1'b1;
        end
      end
    end
  end

  assign bus.pad_sel = pad_sel_q;
  assign bus.buttons = buttons_q;
  assign bus.present = present_q;
  assign bus.update  = update_q;
endmodule

// File: tb/tb_genesis_pad_reader.sv
// tb/tb_genesis_pad_reader.sv - directed scoreboard bench for genesis_pad_reader
module tb_genesis_pad_reader;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic pad_on = 1'b0;
  logic [7:0] mask = 8'h00;

  int tests = 0;
  int fails = 0;
  int n;
  logic [8:0] exp_q[$];

  genesis_pad_reader_if bus ();

  genesis_pad_reader #(.SEL_CYCLES(8), .SETTLE_CYCLES(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Pad model: mask uses the output bit order; pins are active-low.
  assign bus.pad_up    = !pad_on || !mask[0];
  assign bus.pad_down  = !pad_on || !mask[1];
  assign bus.pad_left  = pad_on ? (bus.pad_sel ? !mask[2] : 1'b0) : 1'b1;
  assign bus.pad_right = pad_on ? (bus.pad_sel ? !mask[3] : 1'b0) : 1'b1;
  assign bus.pad_a_b   = pad_on ? (bus.pad_sel ? !mask[5] : !mask[4]) : 1'b1;
  assign bus.pad_c_s   = pad_on ? (bus.pad_sel ? !mask[6] : !mask[7]) : 1'b1;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic tick();
    logic [8:0] e;
    @(posedge clock);
    #1;
    if (bus.update === 1'b1) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_update: observed update=1 expected no pending result");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {bus.present, bus.buttons}, e);
      end
    end
  endtask

  task automatic wait_update(input int budget, output int cnt);
    logic got;
    got = 1'b0;
    cnt = 0;
    while (!got && cnt < budget) begin
      tick();
      cnt++;
      if (bus.update === 1'b1) got = 1'b1;
    end
    tests++;
    assert (got) else begin
      fails++;
      $error("FAIL update_timeout: observed no update in %0d cycles expected update", budget);
    end
  endtask

  initial begin
    // Reset with no pad attached.
    repeat (3) tick();
    check("rst_pad_sel", {8'h00, bus.pad_sel}, 9'h001);
    check("rst_buttons", {1'b0, bus.buttons}, 9'h000);
    check("rst_present", {8'h00, bus.present}, 9'h000);
    check("rst_update",  {8'h00, bus.update}, 9'h000);

    reset = 1'b1;
    exp_q.push_back({1'b0, 8'h00});
    wait_update(40, n);
    check("first_update_latency", 9'(n), 9'd11);
    repeat (4) tick();
    check("pad_sel_low_hold", {8'h00, bus.pad_sel}, 9'h000);
    tick();
    check("pad_sel_high_again", {8'h00, bus.pad_sel}, 9'h001);
    exp_q.push_back({1'b0, 8'h00});
    wait_update(40, n);
    check("poll_period_tail", 9'(n), 9'd11);

    // Pad present, nothing pressed.
    pad_on = 1'b1;
    mask   = 8'h00;
    exp_q.push_back({1'b1, 8'h00});
    wait_update(40, n);
    check("poll_period", 9'(n), 9'd16);
    tick();
    check("update_one_cycle", {8'h00, bus.update}, 9'h000);

    // Up + B + Start on two consecutive polls.
    mask = 8'hA1;
    exp_q.push_back({1'b1, 8'hA1});
    exp_q.push_back({1'b1, 8'hA1});
    wait_update(40, n);
    wait_update(40, n);
    check("hold_after_poll", 9'(n), 9'd16);

    // A + C + right.
    mask = 8'h58;
    exp_q.push_back({1'b1, 8'h58});
    wait_update(40, n);

    // Change pins one cycle before the HIGH sample: only the LOW half sees it.
    repeat (6) tick();
    mask = 8'h01;
    exp_q.push_back({1'b1, 8'h48});
    exp_q.push_back({1'b1, 8'h01});
    wait_update(40, n);
    check("late_change_poll", 9'(n), 9'd10);
    wait_update(40, n);
    check("late_change_next", 9'(n), 9'd16);

    // Reset at cycle 5 of the LOW phase.
    repeat (2) tick();
    mask  = 8'h81;
    reset = 1'b0;
    tick();
    check("midrst_pad_sel", {8'h00, bus.pad_sel}, 9'h001);
    check("midrst_outputs", {bus.present, bus.buttons}, 9'h000);
    check("midrst_update",  {8'h00, bus.update}, 9'h000);
    repeat (2) tick();
    reset = 1'b1;
    exp_q.push_back({1'b1, 8'h81});
    wait_update(40, n);
    check("midrst_first_update", 9'(n), 9'd11);

    check("queue_drained", 9'(exp_q.size()), 9'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
